cpu_regfile_rd_sched: RTL and testbench
=======================================

# cpu_regfile_rd_sched

Read scheduler for the single-port synchronous-read register file. It accepts one two-operand read request from the decode stage and serialises the rs1 and rs2 reads onto the single RAM port. Write-back always has priority on that port, and the scheduler forwards any write-back that hits a pending operand. It sits between decode/issue and `cpu_regfile_sync_1r1w`, and replaces the ad-hoc enable muxing used when `p_rf_sp = 1`.

## Interface
Parameters:
- `p_ext_rve`, default 0: RV32E mode; addresses 16..31 are out of bounds.
- `p_bypass`, default 1: forward write-back data into pending or latched operands; when 0, matching writes are ignored.

Ports:
- `i_clk`  in  1  global clock; only clock.
- `i_rst`  in  1  global reset; synchronous, active-high.
- `i_req_valid`  in  1  read request valid.
- `o_req_ready`  out  1  request accepted; high only in IDLE with `!i_ram_busy`.
- `i_rs1_addr`, `i_rs2_addr`  in  5  operand addresses.
- `i_rs1_used`, `i_rs2_used`  in  1  operand required.
- `o_op_valid`  out  1  operands ready.
- `i_op_ready`  in  1  consumer accepts operands.
- `o_rs1_data`, `o_rs2_data`  out  32  operand values.
- `o_addr_oob`  out  1  accepted request had an out-of-bounds used address; valid with `o_op_valid`.
- `o_ram_rd_en`  out  1  RAM read strobe.
- `o_ram_addr`  out  5  RAM read address.
- `i_ram_data`  in  32  RAM read data, valid the cycle after `o_ram_rd_en`.
- `i_ram_busy`  in  1  RAM busy (init/clear); blocks accepts and reads.
- `i_wr_en`  in  1  write-back enable; also owns the RAM port this cycle.
- `i_wr_addr`  in  5  write-back address.
- `i_wr_data`  in  32  write-back data.

## Operation
- FSM states: IDLE, RD1, CAP1, RD2, CAP2, OUT.
- IDLE: on `i_req_valid && o_req_ready`, latch both addresses and used flags, clear the operand registers, and go to RD1.
- An operand is **resolved**, with value 0 and no RAM access, if any of these hold:
  - its used flag is 0;
  - its address is 0;
  - its address is out of bounds (`p_ext_rve` and addr[4] = 1). This case also sets the oob flag.
- RD*n*: if operand *n* is resolved, skip directly to RD2 (from RD1) or OUT (from RD2).
  - If `!i_wr_en && !i_ram_busy`, assert `o_ram_rd_en` with `o_ram_addr = rsn` and go to CAP*n*.
  - Otherwise stay in RD*n*; the read is retried.
- CAP*n*: capture `i_ram_data` into operand *n*, mark it resolved, and go to RD2 (from CAP1) or OUT (from CAP2).
- OUT: hold `o_op_valid = 1` with stable data until `i_op_ready`, then go to IDLE. There is no accept in the same cycle as the OUT handshake.
- Bypass (`p_bypass = 1`), active in every state after accept:
  - Condition: `i_wr_en && i_wr_addr == rsn && rsn != 0 && used_n && !oob_n`.
  - Effect: operand *n* takes `i_wr_data` and is marked resolved.
  - Bypass beats RAM capture in CAP*n*, because the RAM data is stale.
  - A hit in RD*n* also cancels that read.
  - In OUT, a hit updates the presented data.
  - If both operands match, both are updated.
- `o_ram_addr = 0` whenever `o_ram_rd_en = 0`.
- `o_addr_oob` is 0 outside OUT.

## Timing
- Reset takes effect at the next clock edge and is allowed mid-operation. It returns the FSM to IDLE and zeroes all operand and flag registers; an in-flight RAM read is discarded.
- Reset values: `o_op_valid` = 0, `o_rs1_data`/`o_rs2_data` = 0, `o_ram_rd_en` = 0, `o_ram_addr` = 0, `o_addr_oob` = 0, `o_req_ready` = `!i_ram_busy`.
- Best-case latency, both operands read from RAM, no writes:
  - accept at cycle t;
  - RD1 at t+1, CAP1 at t+2;
  - RD2 at t+3, CAP2 at t+4;
  - `o_op_valid` at t+5.
- Each resolved-at-RD operand saves 2 cycles. With both resolved, `o_op_valid` rises at t+3 (RD1 and RD2 pass through).
- Each cycle with `i_wr_en` or `i_ram_busy` in RD*n* adds 1 cycle.
- `o_req_ready`, `o_ram_rd_en` and `o_ram_addr` are combinational from state and inputs. All data outputs are registered.

## Test plan
- **Plain read:** RAM x5 = 0xAAAA0001, x6 = 0x5555_0002; request rs1 = 5, rs2 = 6 -> `o_ram_rd_en` at t+1 (addr 5) and t+3 (addr 6); `o_op_valid` at t+5 with data 0xAAAA0001 / 0x55550002.
- **Zero and unused:** rs1 = 0, rs2 = 9 with `i_rs2_used` = 0 -> no `o_ram_rd_en`; `o_op_valid` at t+3 with both data = 0.
- **Write contention:** `i_wr_en` held high at t+1..t+3 to address 12; request rs1 = 3 -> read of x3 issued at t+4; `o_op_valid` delayed by exactly 3 cycles.
- **Bypass:**
  - Write x7 = 0xDEADBEEF during CAP1 of rs1 = 7 -> `o_rs1_data` = 0xDEADBEEF, not the RAM value.
  - Write to x7 during OUT -> presented data updates next cycle.
  - Repeat with `p_bypass = 0` -> the stale RAM value is kept.
- **RV32E oob:** `p_ext_rve = 1`, rs2 = 20 used -> no read at address 20; `o_addr_oob` = 1 with `o_op_valid`; `o_rs2_data` = 0.
- **Reset mid-op:** assert `i_rst` in CAP1 -> next cycle IDLE; all outputs at reset values; the next request completes normally.

Source files
------------

// File: rtl/cpu_regfile_rd_sched.sv
// Serialises rs1/rs2 reads onto the single register-file RAM port, forwarding hitting write-backs.
// Latency: 5 cycles accept-to-valid with two RAM reads; write-back or RAM busy stalls the reads; operands held until i_op_ready.
module cpu_regfile_rd_sched #(
    parameter int unsigned p_ext_rve = 0,
    parameter int unsigned p_bypass  = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    input  logic        i_rs1_used,
    input  logic        i_rs2_used,
    output logic        o_op_valid,
    input  logic        i_op_ready,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    output logic        o_addr_oob,
    output logic        o_ram_rd_en,
    output logic [4:0]  o_ram_addr,
    input  logic [31:0] i_ram_data,
    input  logic        i_ram_busy,
    input  logic        i_wr_en,
    input  logic [4:0]  i_wr_addr,
    input  logic [31:0] i_wr_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD1  = 3'd1;
    localparam logic [2:0] S_CAP1 = 3'd2;
    localparam logic [2:0] S_RD2  = 3'd3;
    localparam logic [2:0] S_CAP2 = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    localparam logic rve_en = (p_ext_rve != 0);
    localparam logic byp_en = (p_bypass != 0);

    logic [2:0]  state_q, state_d;
    logic [4:0]  rs1_q, rs2_q;
    logic        used1_q, used2_q;
    logic        oob1_q, oob2_q;
    logic        res1_q, res2_q;
    logic [31:0] dat1_q, dat2_q;

    logic        accept;
    logic        in_oob1, in_oob2;
    logic        in_res1, in_res2;
    logic        byp1, byp2;
    logic        rd_req;
    logic [4:0]  rd_addr;

    assign o_req_ready = (state_q == S_IDLE) && !i_ram_busy;
    assign accept      = i_req_valid && o_req_ready;

    // Out-of-bounds only matters for operands that are actually used.
    assign in_oob1 = rve_en && i_rs1_used && i_rs1_addr[4];
    assign in_oob2 = rve_en && i_rs2_used && i_rs2_addr[4];
    assign in_res1 = !i_rs1_used || (i_rs1_addr == 5'd0) || in_oob1;
    assign in_res2 = !i_rs2_used || (i_rs2_addr == 5'd0) || in_oob2;

    assign byp1 = byp_en && (state_q != S_IDLE) && i_wr_en && (i_wr_addr == rs1_q)
                  && (rs1_q != 5'd0) && used1_q && !oob1_q;
    assign byp2 = byp_en && (state_q != S_IDLE) && i_wr_en && (i_wr_addr == rs2_q)
                  && (rs2_q != 5'd0) && used2_q && !oob2_q;

    always_comb begin
        rd_req  = 1'b0;
        rd_addr = 5'd0;
        if (!i_wr_en && !i_ram_busy) begin
            if (state_q == S_RD1 && !res1_q) begin
                rd_req  = 1'b1;
                rd_addr = rs1_q;
            end else if (state_q == S_RD2 && !res2_q) begin
                rd_req  = 1'b1;
                rd_addr = rs2_q;
            end
        end
    end

    assign o_ram_rd_en = rd_req;
    assign o_ram_addr  = rd_addr;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_RD1;
            S_RD1: begin
                if (res1_q)      state_d = S_RD2;
                else if (rd_req) state_d = S_CAP1;
            end
            S_CAP1: state_d = S_RD2;
            S_RD2: begin
                if (res2_q)      state_d = S_OUT;
                else if (rd_req) state_d = S_CAP2;
            end
            S_CAP2: state_d = S_OUT;
            S_OUT:  if (i_op_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            used1_q <= 1'b0;
            used2_q <= 1'b0;
            oob1_q  <= 1'b0;
            oob2_q  <= 1'b0;
            res1_q  <= 1'b0;
            res2_q  <= 1'b0;
            dat1_q  <= 32'd0;
            dat2_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rs1_q   <= i_rs1_addr;
                rs2_q   <= i_rs2_addr;
                used1_q <= i_rs1_used;
                used2_q <= i_rs2_used;
                oob1_q  <= in_oob1;
                oob2_q  <= in_oob2;
                res1_q  <= in_res1;
                res2_q  <= in_res2;
                dat1_q  <= 32'd0;
                dat2_q  <= 32'd0;
            end else begin
                // A write-back in the capture cycle makes the RAM data stale, so it wins.
                if (byp1) begin
                    dat1_q <= i_wr_data;
                    res1_q <= 1'b1;
                end else if (state_q == S_CAP1) begin
                    dat1_q <= i_ram_data;
                    res1_q <= 1'b1;
                end
                if (byp2) begin
                    dat2_q <= i_wr_data;
                    res2_q <= 1'b1;
                end else if (state_q == S_CAP2) begin
                    dat2_q <= i_ram_data;
                    res2_q <= 1'b1;
                end
            end
        end
    end

    assign o_op_valid = (state_q == S_OUT);
    assign o_rs1_data = dat1_q;
    assign o_rs2_data = dat2_q;
    assign o_addr_oob = (state_q == S_OUT) && (oob1_q || oob2_q);

endmodule

// File: tb/tb_cpu_regfile_rd_sched.sv
// Bench for cpu_regfile_rd_sched: default, no-bypass and RV32E instances share stimulus and a register-file RAM model.
module tb_cpu_regfile_rd_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, rs1_used, rs2_used, op_ready, ram_busy, wr_en;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr;
    logic [31:0] wr_data;

    logic [2:0]       req_rdy, op_vld, oob, rd_en;
    logic [2:0][31:0] rs1_dat, rs2_dat;
    logic [2:0][4:0]  ram_addr;

    logic [31:0] mem [32];

    int n_chk  = 0;
    int n_fail = 0;

    // Request currently owned by the scheduler, as the model sees it.
    logic [4:0] cur_a1 = 5'd0, cur_a2 = 5'd0;
    logic       cur_u1 = 1'b0, cur_u2 = 1'b0;
    logic       chk_en = 1'b0;

    int         lat [3];
    int         rd_cnt [3];
    int         rd_c1 [3];
    int         rd_c2 [3];
    logic [4:0] rd_a1 [3];
    logic [4:0] rd_a2 [3];
    logic       rd_hi [3];

    logic [4:0]  pre_a [7] = '{5'd3, 5'd5, 5'd6, 5'd7, 5'd9, 5'd12, 5'd20};
    logic [31:0] pre_d [7] = '{32'h33330003, 32'hAAAA0001, 32'h55550002, 32'h77770007,
                               32'h99990009, 32'h0C0C000C, 32'h20202020};

    always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] rq;
        always @(posedge clk) if (rd_en[g]) rq <= mem[ram_addr[g]];

        cpu_regfile_rd_sched #(
            .p_ext_rve((g == 2) ? 1 : 0),
            .p_bypass ((g == 1) ? 0 : 1)
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_req_valid (req_valid),
            .o_req_ready (req_rdy[g]),
            .i_rs1_addr  (rs1_addr),
            .i_rs2_addr  (rs2_addr),
            .i_rs1_used  (rs1_used),
            .i_rs2_used  (rs2_used),
            .o_op_valid  (op_vld[g]),
            .i_op_ready  (op_ready),
            .o_rs1_data  (rs1_dat[g]),
            .o_rs2_data  (rs2_dat[g]),
            .o_addr_oob  (oob[g]),
            .o_ram_rd_en (rd_en[g]),
            .o_ram_addr  (ram_addr[g]),
            .i_ram_data  (rq),
            .i_ram_busy  (ram_busy),
            .i_wr_en     (wr_en),
            .i_wr_addr   (wr_addr),
            .i_wr_data   (wr_data)
        );
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // With forwarding, a presented operand always equals the current architectural value.
    function automatic logic [31:0] exp_op(input logic [4:0] a, input logic u, input logic rve);
        if (!u || a == 5'd0 || (rve && a[4])) return 32'd0;
        return mem[a];
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int k = 0; k < 3; k++) begin
                if (k != 1) begin
                    if (op_vld[k]) begin
                        chk("model_rs1", rs1_dat[k], exp_op(cur_a1, cur_u1, k == 2));
                        chk("model_rs2", rs2_dat[k], exp_op(cur_a2, cur_u2, k == 2));
                        chk("model_oob", 32'(oob[k]),
                            32'((k == 2) && ((cur_u1 && cur_a1[4]) || (cur_u2 && cur_a2[4]))));
                    end else begin
                        chk("model_oob_idle", 32'(oob[k]), 32'd0);
                    end
                    if (rd_en[k]) begin
                        chk("model_rd_port_free", 32'(wr_en || ram_busy), 32'd0);
                        chk("model_rd_addr", 32'((ram_addr[k] != 5'd0)
                            && !((k == 2) && ram_addr[k][4])
                            && ((cur_u1 && ram_addr[k] == cur_a1) || (cur_u2 && ram_addr[k] == cur_a2))), 32'd1);
                    end else begin
                        chk("model_rd_addr_idle", 32'(ram_addr[k]), 32'd0);
                    end
                end
            end
        end
    end

    task automatic wait_ready;
        int n = 0;
        while (!(&req_rdy) && n < 20) begin
            tick;
            n++;
        end
        chk("req_ready_seen", 32'(&req_rdy), 32'd1);
    endtask

    task automatic issue(input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2);
        wait_ready;
        cur_a1 = a1; cur_a2 = a2; cur_u1 = u1; cur_u2 = u2;
        rs1_addr = a1; rs2_addr = a2; rs1_used = u1; rs2_used = u2;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
    endtask

    // Issue one request, apply write/busy windows (offsets from the accept cycle), run until all three present.
    task automatic run_req(input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                           input int w_lo, input int w_hi, input logic [4:0] wa, input logic [31:0] wd,
                           input int b_lo, input int b_hi);
        int  n = 0;
        logic done = 1'b0;
        issue(a1, a2, u1, u2);
        for (int k = 0; k < 3; k++) begin
            lat[k] = 0; rd_cnt[k] = 0; rd_c1[k] = 0; rd_c2[k] = 0;
            rd_a1[k] = 5'd0; rd_a2[k] = 5'd0; rd_hi[k] = 1'b0;
        end
        while (!done && n < 40) begin
            n++;
            wr_en    = (n >= w_lo && n <= w_hi);
            wr_addr  = wa;
            wr_data  = wd;
            ram_busy = (n >= b_lo && n <= b_hi);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (op_vld[k] && lat[k] == 0) lat[k] = n;
                if (rd_en[k]) begin
                    rd_cnt[k]++;
                    if (rd_cnt[k] == 1) begin rd_c1[k] = n; rd_a1[k] = ram_addr[k]; end
                    else begin rd_c2[k] = n; rd_a2[k] = ram_addr[k]; end
                    if (ram_addr[k][4]) rd_hi[k] = 1'b1;
                end
            end
            done = (lat[0] != 0) && (lat[1] != 0) && (lat[2] != 0);
            if (!done) tick;
        end
        chk("op_valid_within_budget", 32'(done), 32'd1);
        tick;
        wr_en = 1'b0;
        ram_busy = 1'b0;
    endtask

    task automatic ack;
        op_ready = 1'b1;
        tick;
        op_ready = 1'b0;
    endtask

    task automatic out_write(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick;
        wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; rs1_used = 1'b0; rs2_used = 1'b0; op_ready = 1'b0;
        ram_busy = 1'b0; wr_en = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0; wr_addr = 5'd0; wr_data = 32'd0;
        repeat (2) tick;
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; wr_addr = pre_a[i]; wr_data = pre_d[i];
            tick;
        end
        wr_en = 1'b0;
        tick;

        // Reset values, with write-backs during reset ignored by the scheduler.
        @(negedge clk);
        chk("rst_op_valid", 32'(op_vld[0]), 32'd0);
        chk("rst_rs1_data", rs1_dat[0], 32'd0);
        chk("rst_rs2_data", rs2_dat[0], 32'd0);
        chk("rst_rd_en", 32'(rd_en[0]), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr[0]), 32'd0);
        chk("rst_oob", 32'(oob[0]), 32'd0);
        chk("rst_req_ready", 32'(req_rdy[0]), 32'd1);
        tick;
        ram_busy = 1'b1;
        @(negedge clk);
        chk("rst_req_ready_busy", 32'(req_rdy[0]), 32'd0);
        tick;
        ram_busy = 1'b0;
        rst = 1'b0;
        chk_en = 1'b1;
        tick;

        // Plain read of x5 / x6.
        run_req(5'd5, 5'd6, 1'b1, 1'b1, 0, -1, 5'd0, 32'd0, 0, -1);
        chk("plain_latency", 32'(lat[0]), 32'd5);
        chk("plain_rd1_cycle", 32'(rd_c1[0]), 32'd1);
        chk("plain_rd1_addr", 32'(rd_a1[0]), 32'd5);
        chk("plain_rd2_cycle", 32'(rd_c2[0]), 32'd3);
        chk("plain_rd2_addr", 32'(rd_a2[0]), 32'd6);
        chk("plain_rs1", rs1_dat[0], 32'hAAAA0001);
        chk("plain_rs2", rs2_dat[0], 32'h55550002);
        chk("plain_nobyp_rs1", rs1_dat[1], 32'hAAAA0001);
        ack;

        // rs1 = x0 and rs2 unused: no RAM access at all.
        run_req(5'd0, 5'd9, 1'b1, 1'b0, 0, -1, 5'd0, 32'd0, 0, -1);
        chk("zero_latency", 32'(lat[0]), 32'd3);
        chk("zero_rd_count", 32'(rd_cnt[0]), 32'd0);
        chk("zero_rs1", rs1_dat[0], 32'd0);
        chk("zero_rs2", rs2_dat[0], 32'd0);
        ack;

        // Write-back to x12 owns the port for three cycles.
        run_req(5'd3, 5'd0, 1'b1, 1'b1, 1, 3, 5'd12, 32'hC0DE000C, 0, -1);
        chk("contend_rd_cycle", 32'(rd_c1[0]), 32'd4);
        chk("contend_rd_addr", 32'(rd_a1[0]), 32'd3);
        chk("contend_latency", 32'(lat[0]), 32'd7);
        chk("contend_rs1", rs1_dat[0], 32'h33330003);
        ack;

        // RAM busy for two cycles in RD1.
        run_req(5'd6, 5'd0, 1'b1, 1'b0, 0, -1, 5'd0, 32'd0, 1, 2);
        chk("busy_rd_cycle", 32'(rd_c1[0]), 32'd3);
        chk("busy_latency", 32'(lat[0]), 32'd6);
        chk("busy_rs1", rs1_dat[0], 32'h55550002);
        ack;

        // Write x7 during CAP1, then again while presenting.
        run_req(5'd7, 5'd5, 1'b1, 1'b1, 2, 2, 5'd7, 32'hDEADBEEF, 0, -1);
        chk("byp_latency", 32'(lat[0]), 32'd5);
        chk("byp_cap_rs1", rs1_dat[0], 32'hDEADBEEF);
        chk("byp_cap_rs2", rs2_dat[0], 32'hAAAA0001);
        chk("nobyp_cap_rs1", rs1_dat[1], 32'h77770007);
        out_write(5'd7, 32'h12345678);
        chk("byp_out_valid", 32'(op_vld[0]), 32'd1);
        chk("byp_out_rs1", rs1_dat[0], 32'h12345678);
        chk("nobyp_out_rs1", rs1_dat[1], 32'h77770007);
        ack;

        // RV32E: x20 is out of bounds for instance 2 only.
        run_req(5'd5, 5'd20, 1'b1, 1'b1, 0, -1, 5'd0, 32'd0, 0, -1);
        chk("rve_latency", 32'(lat[2]), 32'd4);
        chk("rve_rd_count", 32'(rd_cnt[2]), 32'd1);
        chk("rve_no_hi_read", 32'(rd_hi[2]), 32'd0);
        chk("rve_oob", 32'(oob[2]), 32'd1);
        chk("rve_rs1", rs1_dat[2], 32'hAAAA0001);
        chk("rve_rs2", rs2_dat[2], 32'd0);
        chk("rv32i_hi_read", 32'(rd_hi[0]), 32'd1);
        chk("rv32i_rs2", rs2_dat[0], 32'h20202020);
        out_write(5'd20, 32'hFFFF0000);
        chk("rve_oob_no_bypass", rs2_dat[2], 32'd0);
        chk("rv32i_out_bypass", rs2_dat[0], 32'hFFFF0000);
        ack;
        chk("rve_oob_after_out", 32'(oob[2]), 32'd0);

        // Reset while in CAP1, then a normal request.
        issue(5'd5, 5'd6, 1'b1, 1'b1);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_op_valid", 32'(op_vld[0]), 32'd0);
        chk("midrst_rs1", rs1_dat[0], 32'd0);
        chk("midrst_rs2", rs2_dat[0], 32'd0);
        chk("midrst_rd_en", 32'(rd_en[0]), 32'd0);
        chk("midrst_ram_addr", 32'(ram_addr[0]), 32'd0);
        chk("midrst_req_ready", 32'(req_rdy[0]), 32'd1);
        tick;
        run_req(5'd6, 5'd5, 1'b1, 1'b1, 0, -1, 5'd0, 32'd0, 0, -1);
        chk("postrst_latency", 32'(lat[0]), 32'd5);
        chk("postrst_rs1", rs1_dat[0], 32'h55550002);
        chk("postrst_rs2", rs2_dat[0], 32'hAAAA0001);
        ack;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
